bram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one port of the synchronous dual-port BRAM among NUM_REQ requesters. It drives the BRAM port's write enable, address and write data, and returns read data with a per-requester valid strobe. After reset it can sweep the whole memory to CLEAR_VALUE before accepting traffic. It sits between client logic (packet buffers, register banks) and `bram_sync_dp`, one instance per shared port.

---
 rtl/bram_port_arbiter_pkg.sv | 14 +
 rtl/bram_port_arbiter_rr_arbiter.sv | 33 +++
 rtl/bram_port_arbiter.sv | 109 ++++++++++
 tb/tb_bram_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// bram_port_arbiter_pkg: shared state encoding and tag sizing for the BRAM port arbiter
package bram_port_arbiter_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Width of a requester index, at least one bit.
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin picker searching upward from a pointer with wrap
module rr_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PW      = tag_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      next_ptr
);

    // First requester at or above ptr (wrapping) wins; pointer moves just past it
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        gnt      = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                next_ptr = PW'((int'(idx) + 1) % NUM_REQ);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one BRAM port with optional clear sweep after reset
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int                        NUM_REQ        = 4,
    parameter int                        RAM_DATA_WIDTH = 8,
    parameter int                        RAM_ADDR_WIDTH = 4,
    parameter int                        CLEAR_ON_RESET = 1,
    parameter logic [RAM_DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0]                  req_wr,
    input  logic [NUM_REQ*RAM_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*RAM_DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                  gnt,
    output logic [NUM_REQ-1:0]                  rvalid,
    output logic [RAM_DATA_WIDTH-1:0]           rdata,
    output logic                                busy,
    output logic                                mem_wr,
    output logic [RAM_ADDR_WIDTH-1:0]           mem_addr,
    output logic [RAM_DATA_WIDTH-1:0]           mem_data_in,
    input  logic [RAM_DATA_WIDTH-1:0]           mem_data_out
);

    localparam int TW = tag_width(NUM_REQ);

    state_t                    state, state_nx;
    logic [RAM_ADDR_WIDTH-1:0] clr_addr;
    logic [TW-1:0]             ptr, ptr_nx, sel, tag;
    logic                      arb_en, rd_v;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (req),
        .ptr      (ptr),
        .en       (arb_en),
        .gnt      (gnt),
        .next_ptr (ptr_nx)
    );

    // State register; reset lands in CLEAR only when a sweep is wanted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
        else      state <= state_nx;
    end

    // Leave CLEAR once the top address has been issued
    always_comb state_nx = (state == ST_CLEAR && clr_addr == '1) ? ST_RUN : state;

    // Grants only in RUN and never while reset is held
    always_comb begin
        busy   = state == ST_CLEAR;
        arb_en = state == ST_RUN && rst;
    end

    // Index of the granted requester
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) sel = TW'(i);
    end

    // Sweep address counter and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_addr <= '0;
            ptr      <= '0;
        end else begin
            if (busy) clr_addr <= clr_addr + 1'b1;
            ptr <= ptr_nx;
        end
    end

    // Registered BRAM drive: clear write, granted command, or idle with address/data held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else if (busy) begin
            mem_wr      <= 1'b1;
            mem_addr    <= clr_addr;
            mem_data_in <= CLEAR_VALUE;
        end else if (|gnt) begin
            mem_wr      <= req_wr[sel];
            mem_addr    <= req_addr[sel*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
            mem_data_in <= req_data[sel*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
        end else begin
            mem_wr      <= 1'b0;
        end
    end

    // Two-stage read tag pipeline lining rvalid up with the BRAM read latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_v   <= 1'b0;
            tag    <= '0;
            rvalid <= '0;
        end else begin
            rd_v   <= |gnt & ~req_wr[sel];
            tag    <= sel;
            rvalid <= rd_v ? (NUM_REQ'(1) << tag) : '0;
        end
    end

    // Shared read data, forced to zero when no strobe is up
    always_comb rdata = |rvalid ? mem_data_out : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed and random checks of the arbiter against a grant-order memory model
module tb_bram_port_arbiter;

    localparam int N = 4, AW = 4, DW = 8, DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]    req, req_wr, gnt, rvalid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   rdata, mem_data_in, mem_data_out;
    logic [AW-1:0]   mem_addr;
    logic            busy, mem_wr;
    logic [DW-1:0]   bram [DEPTH];

    logic rst0 = 1'b1;
    logic [N-1:0]    req0, req_wr0, gnt0, rvalid0;
    logic [N*AW-1:0] req_addr0;
    logic [N*DW-1:0] req_data0;
    logic [DW-1:0]   rdata0, mem_data_in0;
    logic [DW-1:0]   mem_data_out0 = 8'h3C;
    logic [AW-1:0]   mem_addr0;
    logic            busy0, mem_wr0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.NUM_REQ(N), .RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW),
                        .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'h00)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out));

    bram_port_arbiter #(.NUM_REQ(N), .RAM_DATA_WIDTH(DW), .RAM_ADDR_WIDTH(AW),
                        .CLEAR_ON_RESET(0), .CLEAR_VALUE(8'h00)) dut0 (
        .clk(clk), .rst(rst0), .req(req0), .req_wr(req_wr0), .req_addr(req_addr0), .req_data(req_data0),
        .gnt(gnt0), .rvalid(rvalid0), .rdata(rdata0), .busy(busy0), .mem_wr(mem_wr0),
        .mem_addr(mem_addr0), .mem_data_in(mem_data_in0), .mem_data_out(mem_data_out0));

    // Synchronous single-port view of the attached BRAM, read-first
    always @(posedge clk) begin
        if (mem_wr) bram[mem_addr] <= mem_data_in;
        mem_data_out <= bram[mem_addr];
    end

    int n_cmp = 0, n_bad = 0;
    int ptr, sweep_left, cyc, next_addr;
    int pend_idx [4];
    logic [DW-1:0] pend_dat [4];
    logic [DW-1:0] mm [DEPTH];
    logic          exp_mw;
    logic [AW-1:0] exp_ma;
    logic [DW-1:0] exp_md;
    bit keep, arrive, wr_mix, seq_addr;
    bit            r_on [N];
    bit            r_wr [N];
    logic [AW-1:0] r_addr [N];
    logic [DW-1:0] r_dat [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]               = r_on[i];
            req_wr[i]            = r_wr[i];
            req_addr[i*AW +: AW] = r_addr[i];
            req_data[i*DW +: DW] = r_dat[i];
        end
    endtask

    task automatic new_cmd(input int i);
        r_on[i]   = 1'b1;
        r_wr[i]   = wr_mix ? bit'($urandom_range(0, 1)) : 1'b0;
        r_addr[i] = seq_addr ? AW'(next_addr) : AW'($urandom_range(0, DEPTH - 1));
        r_dat[i]  = DW'($urandom);
        if (seq_addr) next_addr++;
    endtask

    task automatic reset_model();
        ptr = 0;
        sweep_left = DEPTH;
        exp_mw = 1'b0;
        exp_ma = '0;
        exp_md = '0;
        for (int i = 0; i < 4; i++) pend_idx[i] = -1;
        for (int a = 0; a < DEPTH; a++) mm[a] = 8'h00;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data_in", mem_data_in, 0);
        chk("rst_busy", busy, 1);
        reset_model();
        @(posedge clk);
        #1 rst = 1'b1;
        cyc = 0;
        @(negedge clk);
    endtask

    // One cycle: check outputs against the model, then advance model and requesters
    task automatic step();
        int w, i, s;
        logic busy_e;
        logic [N-1:0] g_e, rv_e;
        drive();
        #1;
        w = -1;
        busy_e = sweep_left > 0;
        if (!busy_e)
            for (int k = 0; k < N; k++) begin
                i = (ptr + k) % N;
                if (w < 0 && r_on[i]) w = i;
            end
        g_e = (w < 0) ? '0 : (N'(1) << w);
        chk("gnt", gnt, g_e);
        chk("busy", busy, busy_e);
        chk("mem_wr", mem_wr, exp_mw);
        chk("mem_addr", mem_addr, exp_ma);
        if (exp_mw) chk("mem_data_in", mem_data_in, exp_md);
        s = cyc % 4;
        rv_e = (pend_idx[s] < 0) ? '0 : (N'(1) << pend_idx[s]);
        chk("rvalid", rvalid, rv_e);
        chk("rdata", rdata, (pend_idx[s] < 0) ? 32'd0 : 32'(pend_dat[s]));
        pend_idx[s] = -1;
        if (busy_e) begin
            exp_mw = 1'b1;
            exp_ma = AW'(DEPTH - sweep_left);
            exp_md = 8'h00;
            sweep_left--;
        end else if (w >= 0) begin
            exp_mw = r_wr[w];
            exp_ma = r_addr[w];
            exp_md = r_dat[w];
            if (r_wr[w]) mm[r_addr[w]] = r_dat[w];
            else begin
                pend_idx[(cyc + 2) % 4] = w;
                pend_dat[(cyc + 2) % 4] = mm[r_addr[w]];
            end
            ptr = (w + 1) % N;
        end else begin
            exp_mw = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (w >= 0) begin
            if (keep) new_cmd(w);
            else r_on[w] = 1'b0;
        end
        if (arrive)
            for (int k = 0; k < N; k++)
                if (!r_on[k] && $urandom_range(0, 1) == 1) new_cmd(k);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            r_on[i] = 0; r_wr[i] = 0; r_addr[i] = '0; r_dat[i] = '0;
        end
        keep = 0; arrive = 0; wr_mix = 0; seq_addr = 0; next_addr = 0; cyc = 0;
        req0 = '0; req_wr0 = '0; req_addr0 = '0; req_data0 = '0;
        drive();
        #2 rst = 1'b0;

        // Sweep with alternating requesters 1 and 3 arriving during busy
        do_reset();
        for (int k = 0; k < 3; k++) step();
        keep = 1;
        new_cmd(1);
        new_cmd(3);
        while (cyc < DEPTH) step();
        drive(); #1;
        chk("busy_fall", busy, 0);
        chk("rr_1010_first", gnt, 4'b0010);
        step();
        drive(); #1;
        chk("rr_1010_second", gnt, 4'b1000);
        step();
        drive(); #1;
        chk("rr_1010_third", gnt, 4'b0010);
        step();

        // All four reading back-to-back through every address
        seq_addr = 1; next_addr = 0;
        for (int i = 0; i < N; i++) new_cmd(i);
        for (int k = 0; k < 22; k++) step();

        // Write then read of the same address in consecutive grants
        keep = 0; seq_addr = 0;
        for (int i = 0; i < N; i++) r_on[i] = 0;
        r_on[2] = 1; r_wr[2] = 1; r_addr[2] = 4'd6; r_dat[2] = 8'hA5;
        step();
        r_on[0] = 1; r_wr[0] = 0; r_addr[0] = 4'd6;
        step();
        step();
        chk("raw_rvalid", rvalid, 4'b0001);
        chk("raw_rdata", rdata, 8'hA5);
        step();

        // Reset while reads are in flight, then again mid-sweep
        keep = 1;
        for (int i = 0; i < N; i++) new_cmd(i);
        for (int k = 0; k < 5; k++) step();
        do_reset();
        for (int k = 0; k < 6; k++) step();
        do_reset();
        for (int k = 0; k < 24; k++) step();

        // Random traffic with a reset in the middle
        keep = 0; arrive = 1; wr_mix = 1;
        for (int k = 0; k < 150; k++) step();
        do_reset();
        for (int k = 0; k < 150; k++) step();
        arrive = 0;
        for (int i = 0; i < N; i++) r_on[i] = 0;
        for (int k = 0; k < 4; k++) step();

        // No-sweep instance: granted in the first cycle after reset release
        @(posedge clk);
        #1 rst0 = 1'b0;
        req0 = 4'b0100; req_wr0 = '0; req_addr0 = {4'd0, 4'd9, 4'd0, 4'd0};
        #1;
        chk("ns_rst_busy", busy0, 0);
        chk("ns_rst_gnt", gnt0, 0);
        chk("ns_rst_mem_wr", mem_wr0, 0);
        chk("ns_rst_rvalid", rvalid0, 0);
        @(posedge clk);
        #1 rst0 = 1'b1;
        #1;
        chk("ns_first_gnt", gnt0, 4'b0100);
        chk("ns_busy", busy0, 0);
        @(posedge clk);
        #1 req0 = '0;
        #1;
        chk("ns_mem_wr", mem_wr0, 0);
        chk("ns_mem_addr", mem_addr0, 4'd9);
        chk("ns_gnt_idle", gnt0, 0);
        @(posedge clk);
        #2;
        chk("ns_rvalid", rvalid0, 4'b0100);
        chk("ns_rdata", rdata0, 8'h3C);
        @(posedge clk);
        #2;
        chk("ns_rvalid_off", rvalid0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
